// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion engine: steps and bounces a ball once per
// FRAME_DIV vsync falling edges, then writes X and Y to the display peripheral.
module ball_motion_ctrl #(
    parameter int DW        = 10,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int BALL_SIZE = 16,
    parameter int X_INIT    = 100,
    parameter int Y_INIT    = 100,
    parameter int VX        = 2,
    parameter int VY        = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_vs,
    input  logic          enable,
    output logic          chipselect,
    output logic          write,
    output logic [2:0]    address,
    output logic [DW-1:0] writedata,
    output logic [DW-1:0] x_pos,
    output logic [DW-1:0] y_pos,
    output logic          bounce
);

    // state  | meaning
    // IDLE   | waiting for a due frame tick, bus idle
    // UPDATE | new position and directions registered
    // WR_X   | bus write of x_pos to address 0
    // WR_Y   | bus write of y_pos to address 1
    typedef enum logic [1:0] {IDLE, UPDATE, WR_X, WR_Y} state_t;

    localparam int W1  = DW + 1;
    localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [W1-1:0] X_LIM = W1'(X_MAX - BALL_SIZE);
    localparam logic [W1-1:0] Y_LIM = W1'(Y_MAX - BALL_SIZE);

    state_t         state;
    logic           vs_d;
    logic [FCW-1:0] frame_cnt;
    logic           dx, dy;
    logic           tick, due;

    logic [W1-1:0]  x_ext, y_ext, x_sum, y_sum;
    logic [DW-1:0]  x_nxt, y_nxt;
    logic           dx_nxt, dy_nxt, bx, by;

    assign tick  = vs_d & ~vga_vs;
    assign due   = (frame_cnt == FCW'(FRAME_DIV - 1));
    assign x_ext = {1'b0, x_pos};
    assign y_ext = {1'b0, y_pos};
    assign x_sum = x_ext + W1'(VX);
    assign y_sum = y_ext + W1'(VY);

    // Extra bit on the sums keeps the wall compare honest near the top of the range
    always_comb begin
        x_nxt  = x_pos;
        dx_nxt = dx;
        bx     = 1'b0;
        if (dx) begin
            if (x_sum >= X_LIM) begin
                x_nxt  = DW'(X_LIM);
                dx_nxt = 1'b0;
                bx     = 1'b1;
            end else begin
                x_nxt = x_sum[DW-1:0];
            end
        end else begin
            if (x_ext <= W1'(VX)) begin
                x_nxt  = '0;
                dx_nxt = 1'b1;
                bx     = 1'b1;
            end else begin
                x_nxt = x_pos - DW'(VX);
            end
        end
    end

    always_comb begin
        y_nxt  = y_pos;
        dy_nxt = dy;
        by     = 1'b0;
        if (dy) begin
            if (y_sum >= Y_LIM) begin
                y_nxt  = DW'(Y_LIM);
                dy_nxt = 1'b0;
                by     = 1'b1;
            end else begin
                y_nxt = y_sum[DW-1:0];
            end
        end else begin
            if (y_ext <= W1'(VY)) begin
                y_nxt  = '0;
                dy_nxt = 1'b1;
                by     = 1'b1;
            end else begin
                y_nxt = y_pos - DW'(VY);
            end
        end
    end

    // Bus outputs are loaded one cycle ahead so they are pure flops in WR_X/WR_Y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vs_d       <= 1'b1;
            frame_cnt  <= '0;
            dx         <= 1'b1;
            dy         <= 1'b1;
            x_pos      <= DW'(X_INIT);
            y_pos      <= DW'(Y_INIT);
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            bounce     <= 1'b0;
        end else begin
            vs_d       <= vga_vs;
            chipselect <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            bounce     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        if (due) begin
                            frame_cnt <= '0;
                            state     <= UPDATE;
                        end else begin
                            frame_cnt <= frame_cnt + FCW'(1);
                        end
                    end
                end
                UPDATE: begin
                    x_pos      <= x_nxt;
                    y_pos      <= y_nxt;
                    dx         <= dx_nxt;
                    dy         <= dy_nxt;
                    bounce     <= bx | by;
                    chipselect <= 1'b1;
                    write      <= 1'b1;
                    address    <= 3'd0;
                    writedata  <= x_nxt;
                    state      <= WR_X;
                end
                WR_X: begin
                    chipselect <= 1'b1;
                    write      <= 1'b1;
                    address    <= 3'd1;
                    writedata  <= y_pos;
                    state      <= WR_Y;
                end
                WR_Y: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: default, wall-bounce and divide-by-3 instances.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vga_vs = 1'b1;
    logic enable = 1'b1;

    always #10 clk = ~clk;

    logic       cs_a, wr_a, bn_a, cs_b, wr_b, bn_b, cs_c, wr_c, bn_c;
    logic [2:0] ad_a, ad_b, ad_c;
    logic [9:0] wd_a, wd_b, wd_c, x_a, y_a, x_b, y_b, x_c, y_c;

    ball_motion_ctrl u_a (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .enable(enable),
        .chipselect(cs_a), .write(wr_a), .address(ad_a), .writedata(wd_a),
        .x_pos(x_a), .y_pos(y_a), .bounce(bn_a)
    );

    ball_motion_ctrl #(.X_INIT(623), .Y_INIT(1), .Y_MAX(18)) u_b (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .enable(enable),
        .chipselect(cs_b), .write(wr_b), .address(ad_b), .writedata(wd_b),
        .x_pos(x_b), .y_pos(y_b), .bounce(bn_b)
    );

    ball_motion_ctrl #(.FRAME_DIV(3)) u_c (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .enable(enable),
        .chipselect(cs_c), .write(wr_c), .address(ad_c), .writedata(wd_c),
        .x_pos(x_c), .y_pos(y_c), .bounce(bn_c)
    );

    // Each captured write is {bounce, address, writedata}
    logic [13:0] qa[$], qb[$], qc[$];
    int n_pass = 0;
    int n_chk  = 0;

    always @(negedge clk) begin
        if (wr_a) qa.push_back({bn_a, ad_a, wd_a});
        if (wr_b) qb.push_back({bn_b, ad_b, wd_b});
        if (wr_c) qc.push_back({bn_c, ad_c, wd_c});
    end

    function automatic logic [13:0] ent(input logic b, input logic [2:0] a, input logic [9:0] d);
        return {b, a, d};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        vga_vs = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic vs_edge();
        @(negedge clk);
        vga_vs = 1'b0;
        repeat (4) @(negedge clk);
        vga_vs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    logic [13:0] exp_b[8];
    logic [13:0] got_e;

    initial begin
        // Reset state and first update with exact cycle timing
        do_reset();
        check("rst_x", x_a, 100);
        check("rst_y", y_a, 100);
        check("rst_cs", cs_a, 0);
        check("rst_wd", wd_a, 0);
        @(negedge clk);
        vga_vs = 1'b0;
        @(posedge clk); #1;
        check("t1_cs", cs_a, 0);
        @(posedge clk); #1;
        check("t2_cs", cs_a, 1);
        check("t2_wr", wr_a, 1);
        check("t2_ad", ad_a, 0);
        check("t2_wd", wd_a, 102);
        check("t2_bn", bn_a, 0);
        check("t2_x", x_a, 102);
        @(posedge clk); #1;
        check("t3_wr", wr_a, 1);
        check("t3_ad", ad_a, 1);
        check("t3_wd", wd_a, 101);
        @(posedge clk); #1;
        check("t4_cs", cs_a, 0);
        check("t4_wr", wr_a, 0);
        @(negedge clk);
        vga_vs = 1'b1;
        repeat (6) @(negedge clk);
        check("t_nwr", qa.size(), 2);

        // Wall reflections: X off the right wall, Y off bottom then top
        do_reset();
        for (int i = 0; i < 4; i++) vs_edge();
        exp_b[0] = ent(1, 0, 624); exp_b[1] = ent(0, 1, 2);
        exp_b[2] = ent(0, 0, 622); exp_b[3] = ent(0, 1, 1);
        exp_b[4] = ent(1, 0, 620); exp_b[5] = ent(0, 1, 0);
        exp_b[6] = ent(0, 0, 618); exp_b[7] = ent(0, 1, 1);
        check("b_nwr", qb.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got_e = (i < qb.size()) ? qb[i] : 14'h3fff;
            check($sformatf("b_w%0d", i), got_e, exp_b[i]);
        end

        // Frozen motion with enable low, then a normal update
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) vs_edge();
        check("en0_nwr", qa.size(), 0);
        check("en0_x", x_a, 100);
        check("en0_y", y_a, 100);
        enable = 1'b1;
        vs_edge();
        check("en1_nwr", qa.size(), 2);
        got_e = (qa.size() > 1) ? qa[0] : 14'h3fff;
        check("en1_w0", got_e, ent(0, 0, 102));
        got_e = (qa.size() > 1) ? qa[1] : 14'h3fff;
        check("en1_w1", got_e, ent(0, 1, 101));
        check("en1_c_nwr", qc.size(), 0);

        // Divide by three: writes only after edges 3 and 6
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            vs_edge();
            check($sformatf("div_e%0d", e), qc.size(), (e / 3) * 2);
        end
        got_e = (qc.size() == 4) ? qc[2] : 14'h3fff;
        check("div_w2", got_e, ent(0, 0, 104));
        got_e = (qc.size() == 4) ? qc[3] : 14'h3fff;
        check("div_w3", got_e, ent(0, 1, 102));

        // Reset asserted in the WR_X cycle kills the sequence at once
        do_reset();
        @(negedge clk);
        vga_vs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rx_cs_pre", cs_a, 1);
        #2 reset = 1'b1;
        #1;
        check("rx_cs", cs_a, 0);
        check("rx_wr", wr_a, 0);
        vga_vs = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rx_nwr", qa.size(), 0);
        check("rx_x", x_a, 100);
        check("rx_y", y_a, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
